sim_run_monitor: RTL and testbench

Parametrised run-control and console monitor attached to the RISC_V core in simulation and FPGA debug builds. Counts program wraps back to the reset vector and declares run completion after a programmable number of wraps plus a drain window. Watchdog timeout ends a hung run. Decodes the core's serial uart_tx_out stream into bytes and buffers them in a FIFO for the bench or host to drain.

---
 rtl/sim_run_monitor_pkg.sv | 24 ++
 rtl/sim_run_monitor_uart_rx_decoder.sv | 123 ++++++++++++
 rtl/sim_run_monitor.sv | 194 +++++++++++++++++++
 tb/tb_sim_run_monitor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_run_monitor_pkg.sv
// rtl/sim_run_monitor_pkg.sv - shared state encodings for the run monitor
//
// Purpose : state enums and constants used by sim_run_monitor and its
//           UART decoder.
// Contents: run_fsm_state_t, uart_rx_state_t, UART_DATA_BITS.
package Run_Monitor_enum;

  typedef enum logic [1:0] {
    RUN_ACTIVE,
    RUN_DRAIN,
    RUN_DONE,
    RUN_TIMEOUT
  } run_fsm_state_t;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/sim_run_monitor_uart_rx_decoder.sv
// rtl/sim_run_monitor_uart_rx_decoder.sv - 8N1 serial byte decoder
//
// Purpose : decodes an idle-high 8N1 LSB-first serial line into bytes.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           line             - raw serial input (registered internally)
//           rx_byte          - assembled byte, valid while byte_valid = 1
//           byte_valid       - one-cycle strobe on a good stop bit
//           frame_err        - one-cycle strobe on a low stop bit
module uart_rx_decoder
  import Run_Monitor_enum::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       line,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(UART_DATA_BITS - 1);

  uart_rx_state_t            state, state_n;
  logic                      line_q, line_prev;
  logic [CW-1:0]             cnt, cnt_n;
  logic [2:0]                bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  // Set after a bad stop bit: hold in STOP until the line returns high so a
  // break condition cannot be mistaken for a new start bit.
  logic                      err_wait, err_wait_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UART_IDLE;
      line_q    <= 1'b1;
      line_prev <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      err_wait  <= 1'b0;
    end else begin
      state     <= state_n;
      line_q    <= line;
      line_prev <= line_q;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      err_wait  <= err_wait_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    err_wait_n = err_wait;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (state)
      UART_IDLE: begin
        cnt_n = '0;
        if (line_prev && !line_q) state_n = UART_START;
      end
      UART_START: begin
        // Mid start-bit check rejects glitches shorter than half a bit.
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (line_q) begin
            state_n = UART_IDLE;
          end else begin
            state_n   = UART_DATA;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      UART_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {line_q, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == LAST_BIT) begin
            state_n    = UART_STOP;
            err_wait_n = 1'b0;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      UART_STOP: begin
        if (err_wait) begin
          if (line_q) begin
            state_n    = UART_IDLE;
            err_wait_n = 1'b0;
          end
        end else if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (line_q) begin
            byte_valid = 1'b1;
            state_n    = UART_IDLE;
          end else begin
            frame_err  = 1'b1;
            err_wait_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: state_n = UART_IDLE;
    endcase
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/sim_run_monitor.sv
// rtl/sim_run_monitor.sv - run-control, watchdog and console monitor
//
// Purpose : counts wraps of the core PC to RESET_VECTOR, ends the run after
//           WRAP_COUNT wraps plus a POST_CYCLES drain, ends a hung run by
//           watchdog, and buffers bytes decoded from the core UART TX line.
// Ports   : clk, rst               - clock, synchronous active-high reset
//           pc_i, pc_valid_i       - observed PC and its update strobe
//           uart_tx_in             - core serial TX line, idle high
//           rx_data_o, rx_valid_o  - show-ahead FIFO head and not-empty
//           rx_ready_i             - pop when rx_valid_o is also high
//           rx_frame_err_o         - one-cycle bad-stop-bit pulse
//           overflow_o             - sticky byte-dropped flag
//           wrap_cnt_o             - saturating wrap count
//           run_done_o, timeout_o  - sticky terminal status
//           state_o                - run FSM state
module sim_run_monitor
  import Run_Monitor_enum::*;
#(
  parameter int              DATA_WIDTH     = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int              WRAP_COUNT     = 2,
  parameter int              POST_CYCLES    = 2,
  parameter int              TIMEOUT_CYCLES = 100000,
  parameter int              CLKS_PER_BIT   = 16,
  parameter int              FIFO_DEPTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           pc_i,
  input  logic                            pc_valid_i,
  input  logic                            uart_tx_in,
  output logic [7:0]                      rx_data_o,
  output logic                            rx_valid_o,
  input  logic                            rx_ready_i,
  output logic                            rx_frame_err_o,
  output logic                            overflow_o,
  output logic [$clog2(WRAP_COUNT+1)-1:0] wrap_cnt_o,
  output logic                            run_done_o,
  output logic                            timeout_o,
  output run_fsm_state_t                  state_o
);

  localparam int WC_W = $clog2(WRAP_COUNT + 1);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DR_W = (POST_CYCLES > 1) ? $clog2(POST_CYCLES) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);

  localparam logic [WC_W-1:0] WRAP_MAX  = WC_W'(WRAP_COUNT);
  localparam logic [WC_W-1:0] WRAP_LAST = WC_W'(WRAP_COUNT - 1);
  localparam logic [WC_W-1:0] WC_ONE    = WC_W'(1);
  localparam bit              WD_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);
  localparam logic [DR_W-1:0] DR_LAST   = DR_W'((POST_CYCLES > 0) ? POST_CYCLES - 1 : 0);
  localparam logic [DR_W-1:0] DR_ONE    = DR_W'(1);
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [AW:0]     CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]     CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  // ------------------------------------------------------------------
  // Run control
  // ------------------------------------------------------------------
  run_fsm_state_t  state, state_n;
  logic            at_vec;
  logic            wrap;
  logic [WC_W-1:0] wrap_cnt, wrap_cnt_n;
  logic [WD_W-1:0] wd_cnt, wd_n;
  logic [DR_W-1:0] drain_cnt, drain_n;

  // at_vec suppresses re-counting while the core sits on the vector.
  assign wrap = pc_valid_i && (pc_i == RESET_VECTOR) && !at_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN_ACTIVE;
      at_vec    <= 1'b0;
      wrap_cnt  <= '0;
      wd_cnt    <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      wrap_cnt  <= wrap_cnt_n;
      wd_cnt    <= wd_n;
      drain_cnt <= drain_n;
      if (pc_valid_i) at_vec <= (pc_i == RESET_VECTOR);
    end
  end

  always_comb begin
    state_n    = state;
    wrap_cnt_n = wrap_cnt;
    wd_n       = wd_cnt;
    drain_n    = drain_cnt;
    if (wrap && (wrap_cnt != WRAP_MAX)) wrap_cnt_n = wrap_cnt + WC_ONE;
    case (state)
      RUN_ACTIVE: begin
        // The final wrap takes priority over a simultaneous watchdog expiry.
        if (wrap && (wrap_cnt == WRAP_LAST)) begin
          drain_n = '0;
          state_n = (POST_CYCLES == 0) ? RUN_DONE : RUN_DRAIN;
        end else if (WD_EN && (wd_cnt == WD_LAST)) begin
          state_n = RUN_TIMEOUT;
        end else if (WD_EN) begin
          wd_n = wd_cnt + WD_ONE;
        end
      end
      RUN_DRAIN: begin
        if (drain_cnt == DR_LAST) state_n = RUN_DONE;
        else                      drain_n = drain_cnt + DR_ONE;
      end
      default: ;
    endcase
  end

  assign state_o    = state;
  assign wrap_cnt_o = wrap_cnt;
  assign run_done_o = (state == RUN_DONE);
  assign timeout_o  = (state == RUN_TIMEOUT);

  // ------------------------------------------------------------------
  // UART decode
  // ------------------------------------------------------------------
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       frame_err;

  uart_rx_decoder #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .line      (uart_tx_in),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign rx_frame_err_o = frame_err;

  // ------------------------------------------------------------------
  // RX byte FIFO (show-ahead head register)
  // ------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    head, head_n;
  logic          full, pop, do_push, drop;
  logic          overflow;

  assign full    = (count == CNT_FULL);
  assign pop     = (count != '0) && rx_ready_i;
  // A full FIFO still accepts a push when a pop frees a slot this cycle.
  assign do_push = byte_valid && (!full || pop);
  assign drop    = byte_valid && full && !pop;

  // The head register keeps the last byte shown once the FIFO drains.
  always_comb begin
    head_n = head;
    if (pop && (count > CNT_ONE)) begin
      head_n = mem[rd_ptr + PTR_ONE];
    end else if (do_push && ((count == '0) || ((count == CNT_ONE) && pop))) begin
      head_n = rx_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      head <= head_n;
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign rx_data_o  = head;
  assign rx_valid_o = (count != '0);
  assign overflow_o = overflow;

endmodule

// File: tb/tb_sim_run_monitor.sv
// tb/tb_sim_run_monitor.sv - self-checking bench for sim_run_monitor
module tb_sim_run_monitor;
  import Run_Monitor_enum::*;

  localparam int CPB = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    pc_i = '0;
  logic           pc_valid_i = 1'b0;
  logic           uart_tx_in = 1'b1;
  logic [7:0]     rx_data_o;
  logic           rx_valid_o;
  logic           rx_ready_i = 1'b0;
  logic           rx_frame_err_o;
  logic           overflow_o;
  logic [1:0]     wrap_cnt_o;
  logic           run_done_o;
  logic           timeout_o;
  run_fsm_state_t state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_run_monitor #(
    .DATA_WIDTH    (32),
    .RESET_VECTOR  (32'h0000_0000),
    .WRAP_COUNT    (2),
    .POST_CYCLES   (2),
    .TIMEOUT_CYCLES(50),
    .CLKS_PER_BIT  (CPB),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .uart_tx_in    (uart_tx_in),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .rx_frame_err_o(rx_frame_err_o),
    .overflow_o    (overflow_o),
    .wrap_cnt_o    (wrap_cnt_o),
    .run_done_o    (run_done_o),
    .timeout_o     (timeout_o),
    .state_o       (state_o)
  );

  typedef struct {
    logic           r;
    logic           v;
    logic [31:0]    pc;
    logic [1:0]     wrap;
    run_fsm_state_t st;
    logic           done;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(logic r, logic v, logic [31:0] pc, logic [1:0] w,
                              run_fsm_state_t st, logic d);
    vec_t t;
    t.r = r; t.v = v; t.pc = pc; t.wrap = w; t.st = st; t.done = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pc_valid_i = 1'b0;
    rx_ready_i = 1'b0;
    uart_tx_in = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Drives one 8N1 frame; optionally pops during the stop-bit sample cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic pop_at_stop, output int errs);
    logic bitval;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      bitval = 1'b0;
      else if (i == 9) bitval = stop_bit;
      else             bitval = b[i-1];
      for (int j = 0; j < CPB; j++) begin
        uart_tx_in = bitval;
        rx_ready_i = pop_at_stop && (i == 9) && (j == 9);
        step();
        errs += int'(rx_frame_err_o);
      end
    end
    uart_tx_in = 1'b1;
    rx_ready_i = 1'b0;
  endtask

  task automatic idle(input int n, output int errs);
    errs = 0;
    uart_tx_in = 1'b1;
    for (int k = 0; k < n; k++) begin
      step();
      errs += int'(rx_frame_err_o);
    end
  endtask

  task automatic pop_one();
    rx_ready_i = 1'b1;
    step();
    rx_ready_i = 1'b0;
  endtask

  initial begin
    int e;
    logic [7:0] exp_b;

    // ---------------- run-control vectors ----------------
    tbl[0]  = mk(1, 0, 32'h0, 2'd0, RUN_ACTIVE, 0);
    tbl[1]  = mk(1, 0, 32'h0, 2'd0, RUN_ACTIVE, 0);
    tbl[2]  = mk(0, 1, 32'h0, 2'd1, RUN_ACTIVE, 0);
    tbl[3]  = mk(0, 1, 32'h4, 2'd1, RUN_ACTIVE, 0);
    tbl[4]  = mk(0, 1, 32'h8, 2'd1, RUN_ACTIVE, 0);
    tbl[5]  = mk(0, 1, 32'h0, 2'd2, RUN_DRAIN,  0);
    tbl[6]  = mk(0, 1, 32'h4, 2'd2, RUN_DRAIN,  0);
    tbl[7]  = mk(0, 1, 32'h8, 2'd2, RUN_DONE,   1);
    tbl[8]  = mk(0, 1, 32'h0, 2'd2, RUN_DONE,   1);
    tbl[9]  = mk(0, 0, 32'h0, 2'd2, RUN_DONE,   1);
    tbl[10] = mk(1, 0, 32'h0, 2'd0, RUN_ACTIVE, 0);
    for (int i = 11; i < 16; i++) tbl[i] = mk(0, 1, 32'h0, 2'd1, RUN_ACTIVE, 0);
    tbl[16] = mk(0, 1, 32'h4, 2'd1, RUN_ACTIVE, 0);

    for (int i = 0; i < 17; i++) begin
      rst        = tbl[i].r;
      pc_valid_i = tbl[i].v;
      pc_i       = tbl[i].pc;
      step();
      chk($sformatf("vec%0d wrap_cnt", i), 32'(wrap_cnt_o), 32'(tbl[i].wrap));
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("vec%0d run_done", i), 32'(run_done_o), 32'(tbl[i].done));
      chk($sformatf("vec%0d timeout", i), 32'(timeout_o), 32'h0);
    end

    // ---------------- watchdog expiry ----------------
    do_reset();
    pc_valid_i = 1'b0;
    for (int k = 0; k < 49; k++) step();
    chk("wd clk49 timeout", 32'(timeout_o), 32'h0);
    chk("wd clk49 state", 32'(state_o), 32'(RUN_ACTIVE));
    step();
    chk("wd clk50 timeout", 32'(timeout_o), 32'h1);
    chk("wd clk50 state", 32'(state_o), 32'(RUN_TIMEOUT));
    pc_valid_i = 1'b1; pc_i = 32'h0;
    step();
    chk("wd wrap after timeout", 32'(wrap_cnt_o), 32'h1);
    chk("wd terminal", 32'(state_o), 32'(RUN_TIMEOUT));

    // ---------------- final wrap coincides with expiry ----------------
    do_reset();
    pc_valid_i = 1'b1; pc_i = 32'h0;
    step();
    pc_i = 32'h4;
    for (int k = 0; k < 48; k++) step();
    pc_i = 32'h0;
    step();
    chk("tie state", 32'(state_o), 32'(RUN_DRAIN));
    chk("tie timeout", 32'(timeout_o), 32'h0);
    pc_valid_i = 1'b0;
    step();
    step();
    chk("tie done", 32'(run_done_o), 32'h1);
    chk("tie timeout late", 32'(timeout_o), 32'h0);

    // ---------------- UART single byte ----------------
    do_reset();
    chk("rst rx_valid", 32'(rx_valid_o), 32'h0);
    chk("rst rx_data", 32'(rx_data_o), 32'h0);
    send_frame(8'hA5, 1'b1, 1'b0, e);
    chk("A5 valid", 32'(rx_valid_o), 32'h1);
    chk("A5 data", 32'(rx_data_o), 32'hA5);
    chk("A5 no err", 32'(e), 32'h0);
    pop_one();
    chk("A5 popped", 32'(rx_valid_o), 32'h0);
    chk("A5 held", 32'(rx_data_o), 32'hA5);

    // ---------------- back-to-back "Hi" ----------------
    send_frame(8'h48, 1'b1, 1'b0, e);
    send_frame(8'h69, 1'b1, 1'b0, e);
    chk("Hi first", 32'(rx_data_o), 32'h48);
    pop_one();
    chk("Hi second valid", 32'(rx_valid_o), 32'h1);
    chk("Hi second", 32'(rx_data_o), 32'h69);
    pop_one();
    chk("Hi empty", 32'(rx_valid_o), 32'h0);

    // ---------------- glitch and framing error ----------------
    uart_tx_in = 1'b0;
    for (int k = 0; k < 4; k++) step();
    idle(40, e);
    chk("glitch no byte", 32'(rx_valid_o), 32'h0);
    chk("glitch no err", 32'(e), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0, e);
    begin
      int e2;
      idle(20, e2);
      e += e2;
    end
    chk("3C err pulses", 32'(e), 32'h1);
    chk("3C no byte", 32'(rx_valid_o), 32'h0);
    send_frame(8'h5A, 1'b1, 1'b0, e);
    chk("recover data", 32'(rx_data_o), 32'h5A);
    pop_one();

    // ---------------- FIFO overflow ----------------
    do_reset();
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b0, e);
    chk("ovf not yet", 32'(overflow_o), 32'h0);
    send_frame(8'h05, 1'b1, 1'b0, e);
    chk("ovf set", 32'(overflow_o), 32'h1);
    for (int b = 1; b <= 4; b++) begin
      exp_b = 8'(b);
      chk($sformatf("ovf pop%0d valid", b), 32'(rx_valid_o), 32'h1);
      chk($sformatf("ovf pop%0d data", b), 32'(rx_data_o), 32'(exp_b));
      pop_one();
    end
    chk("ovf drained", 32'(rx_valid_o), 32'h0);
    chk("ovf sticky", 32'(overflow_o), 32'h1);

    // ---------------- full FIFO push with simultaneous pop ----------------
    do_reset();
    for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b1, 1'b0, e);
    send_frame(8'h06, 1'b1, 1'b1, e);
    chk("sim no ovf", 32'(overflow_o), 32'h0);
    for (int b = 0; b < 4; b++) begin
      exp_b = (b == 3) ? 8'h06 : 8'(b + 2);
      chk($sformatf("sim pop%0d data", b), 32'(rx_data_o), 32'(exp_b));
      pop_one();
    end
    chk("sim drained", 32'(rx_valid_o), 32'h0);
    chk("sim held last", 32'(rx_data_o), 32'h06);

    // ---------------- reset mid-frame ----------------
    uart_tx_in = 1'b0;
    for (int k = 0; k < 40; k++) step();
    uart_tx_in = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst rx_data", 32'(rx_data_o), 32'h0);
    chk("midrst rx_valid", 32'(rx_valid_o), 32'h0);
    chk("midrst overflow", 32'(overflow_o), 32'h0);
    chk("midrst wrap", 32'(wrap_cnt_o), 32'h0);
    chk("midrst state", 32'(state_o), 32'(RUN_ACTIVE));
    chk("midrst done", 32'(run_done_o), 32'h0);
    chk("midrst timeout", 32'(timeout_o), 32'h0);
    chk("midrst frame_err", 32'(rx_frame_err_o), 32'h0);
    idle(200, e);
    chk("midrst no byte", 32'(rx_valid_o), 32'h0);
    chk("midrst no err", 32'(e), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
